asynchronous_fifo: RTL and testbench
====================================

ASYNCHRONOUS_FIFO -- requirements
Module: asynchronous_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of each stored word.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the storage depth to DEPTH = 2**ADDR_WIDTH (16 words).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 wr_en  input  1  SHALL be the write request.
REQ-007 rd_en  input  1  SHALL be the read request.
REQ-008 data_in  input  DATA_WIDTH  SHALL be the write data, sampled when a write is accepted.
REQ-009 data_out  output  DATA_WIDTH  SHALL be the registered read data.
REQ-010 fifo_full  output  1  SHALL be high when DEPTH words are stored.
REQ-011 fifo_empty  output  1  SHALL be high when zero words are stored.

Function
REQ-012 Write and read pointers SHALL each be ADDR_WIDTH+1 bits wide, with the low ADDR_WIDTH bits addressing storage and the MSB acting as the wrap bit; both wrap modulo 2**(ADDR_WIDTH+1).
REQ-013 Flag equations:
- fifo_empty = (wr_ptr == rd_ptr).
- fifo_full = MSBs differ and the low bits are equal.
- Both flags are decoded combinationally from the registered pointers, so they are valid in the cycle after the pointer update.
REQ-014 Write accept: when wr_en=1 and fifo_full=0 at a clk edge, data_in SHALL be stored at mem[wr_ptr] and wr_ptr SHALL increment by 1.
REQ-015 Read accept: when rd_en=1 and fifo_empty=0 at a clk edge, data_out SHALL load mem[rd_ptr] and rd_ptr SHALL increment by 1.
- Read latency is 1 cycle.
REQ-016 data_out SHALL hold its last value when no read is accepted.
REQ-017 Write when full SHALL be dropped, with no pointer or storage change, even if a read is accepted in the same cycle.
REQ-018 Read when empty SHALL be ignored, with data_out and rd_ptr unchanged, even if a write is accepted in the same cycle.
REQ-019 Simultaneous accepted read and write SHALL both complete in the same cycle, leaving the occupancy unchanged.
REQ-020 Data SHALL be returned strictly in write order across pointer wrap-around.

Reset
REQ-021 While rst=1 at a clk edge, the following SHALL reset and any wr_en/rd_en SHALL be ignored:
- wr_ptr=0, rd_ptr=0, data_out=0.
- Resulting outputs: fifo_empty=1, fifo_full=0.
REQ-022 Storage contents SHALL NOT be reset.
REQ-023 A reset asserted mid-operation SHALL discard all stored data.

Configuration
REQ-024 Macro ASYNC_FIFO_ERR_EN, when defined, SHALL add two outputs:
- overflow (output, 1): sticky, set on a wr_en while full.
- underflow (output, 1): sticky, set on an rd_en while empty.
- Both are cleared only by rst.
REQ-025 Without ASYNC_FIFO_ERR_EN, the overflow and underflow ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package asynchronous_fifo_pkg SHALL hold the following, imported by the module:
- DATA_WIDTH and ADDR_WIDTH defaults.
- The derived DEPTH constant.
- The pointer typedef.
REQ-027 Storage SHALL be one sub-module, fifo_mem: a DEPTH x DATA_WIDTH register array with one synchronous write port and one registered read port.
- Pointer and flag logic stays in asynchronous_fifo.

Verification
REQ-028 Reset: hold rst=1 for 3 clocks with wr_en=rd_en=1 -> data_out=0, fifo_empty=1, fifo_full=0.
REQ-029 Fill: write 0x01..0x10 (16 writes) -> fifo_full=1 after the 16th write, fifo_empty=0; a 17th write of 0xFF is dropped.
REQ-030 Drain: after the fill, read 16 times -> data_out = 0x01..0x10 in order, each one cycle after its rd_en; fifo_empty=1 after the 16th read; a further rd_en leaves data_out=0x10.
REQ-031 Simultaneous access: with 5 words stored, hold wr_en=rd_en=1 for 20 cycles -> occupancy stays 5, no flag toggles, the pointers wrap, and the data stays ordered.
REQ-032 Empty boundary: from empty, assert wr_en=rd_en=1 with data_in=0xA5 -> the write is accepted and the read is ignored; the next cycle rd_en=1 returns 0xA5 and fifo_empty=1.
REQ-033 Error flags (ASYNC_FIFO_ERR_EN defined):
- Write while full -> overflow=1 and it stays set.
- Read while empty -> underflow=1.
- rst clears both.

Source files
------------

// File: rtl/asynchronous_fifo_pkg.sv
// asynchronous_fifo_pkg: default geometry and pointer type shared by the FIFO and its bench.
package asynchronous_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DEPTH = 2 ** DEF_ADDR_WIDTH;
  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;
endpackage

// File: rtl/asynchronous_fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH storage with one synchronous write port and a registered read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // Storage is deliberately left out of reset; only the read register clears.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk)
    rd_data <= rst ? '0 : (rd_en ? mem[rd_addr] : rd_data);
endmodule

// File: rtl/asynchronous_fifo.sv
// asynchronous_fifo: single-clock FIFO with wrap-bit pointers and registered read data.
// Define ASYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module asynchronous_fifo
  import asynchronous_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
`ifdef ASYNC_FIFO_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  fifo_full,
  output logic                  fifo_empty
);
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  assign fifo_empty = wr_ptr == rd_ptr;
  assign fifo_full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  // Acceptance uses the pre-edge flags, so a full write is dropped even alongside a read.
  assign wr_acc = wr_en && !fifo_full && !rst;
  assign rd_acc = rd_en && !fifo_empty && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
      if (rd_acc) rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
    end
  end
`ifdef ASYNC_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && fifo_full) overflow <= 1'b1;
      if (rd_en && fifo_empty) underflow <= 1'b1;
    end
  end
`endif
  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_acc),
    .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data(data_in),
    .rd_en(rd_acc),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(data_out)
  );
endmodule

// File: tb/tb_asynchronous_fifo.sv
// tb_asynchronous_fifo: queue-model scoreboard bench for asynchronous_fifo, directed plus random traffic.
module tb_asynchronous_fifo;
  import asynchronous_fifo_pkg::*;
  localparam int DEPTH = DEF_DEPTH;
  logic clk = 0;
  logic rst = 1, wr_en = 1, rd_en = 1;
  logic [7:0] data_in = 0;
  logic [7:0] data_out;
  logic fifo_full, fifo_empty;
`ifdef ASYNC_FIFO_ERR_EN
  logic overflow, underflow;
  logic exp_ovf = 0, exp_unf = 0;
`endif
  int checks = 0, errors = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last = 0;
  logic rd_fire = 0, rst_fire = 1;
  logic exp_full = 0, exp_empty = 1;

  asynchronous_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .data_out(data_out),
`ifdef ASYNC_FIFO_ERR_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    bit wa, ra;
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd; data_in = d;
    rd_fire = 0;
    rst_fire = r;
    if (r) begin
      model_q.delete();
`ifdef ASYNC_FIFO_ERR_EN
      exp_ovf = 0; exp_unf = 0;
`endif
    end else begin
      wa = w && model_q.size() < DEPTH;
      ra = rd && model_q.size() != 0;
`ifdef ASYNC_FIFO_ERR_EN
      if (w && model_q.size() == DEPTH) exp_ovf = 1;
      if (rd && model_q.size() == 0) exp_unf = 1;
`endif
      if (ra) begin
        exp_q.push_back(model_q.pop_front());
        rd_fire = 1;
      end
      if (wa) model_q.push_back(d);
    end
    exp_empty = model_q.size() == 0;
    exp_full = model_q.size() == DEPTH;
  endtask

  // Monitor: one cycle after each predicted read, retire the oldest expected word.
  always @(posedge clk) begin
    #1;
    if (rst_fire) begin
      last = 0;
      exp_q.delete();
    end else if (rd_fire) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard underrun at %0t", $time);
      end else last = exp_q.pop_front();
    end
    chk("data_out", 32'(data_out), 32'(last));
    chk("fifo_empty", 32'(fifo_empty), 32'(exp_empty));
    chk("fifo_full", 32'(fifo_full), 32'(exp_full));
`ifdef ASYNC_FIFO_ERR_EN
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_unf));
`endif
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1, 1, 1, 8'h5A);
    for (int i = 1; i <= 16; i++) step(0, 1, 0, 8'(i));
    step(0, 1, 0, 8'hFF);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom));
    for (int i = 0; i < 20; i++) step(0, 1, 1, 8'($urandom));
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h00);
    step(0, 1, 1, 8'hA5);
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'($urandom));
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 150; i++) begin
        int wp;
        wp = (p == 0) ? 80 : (p == 1) ? 20 : 50;
        step($urandom_range(0, 199) == 0,
             $urandom_range(0, 99) < wp,
             $urandom_range(0, 99) < 100 - wp + 10,
             8'($urandom));
      end
    end
    step(0, 0, 0, 8'h00);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
